// File: rtl/uart_tx.sv
// UART transmitter (LSB first, 1 start, DATA_BITS data, STOP_BITS stop) with a one-byte holding register.
// Outputs registered; next start bit follows the last stop cycle directly; writes while full are dropped (sticky overrun).
module uart_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] w_data,
    input  logic       write_enable,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_full,
    output logic       tx_done,
    output logic       tx_overrun
);

    localparam int CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int IDX_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 full_q, full_d;
    logic                 ovr_q, ovr_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 bit_end;
    logic                 load;
    logic                 frame_end;

    // State register: outputs are registered copies of the next-state decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            hold_q  <= '0;
            full_q  <= 1'b0;
            ovr_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            ovr_q   <= ovr_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        load      = 1'b0;
        frame_end = 1'b0;
        bit_end   = (cnt_q == CNT_LAST);
        case (state_q)
            S_IDLE: begin
                if (full_q) begin
                    load    = 1'b1;
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == DATA_LAST) begin
                        state_d = S_STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == STOP_LAST) begin
                        frame_end = 1'b1;
                        idx_d     = '0;
                        // A queued byte starts immediately, with no idle bit in between.
                        if (full_q) begin
                            load    = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load) begin
            shift_d = hold_q;
        end
    end

    // A write in the transfer cycle still sees the register full and is dropped.
    always_comb begin
        full_d = full_q;
        hold_d = hold_q;
        ovr_d  = ovr_q;
        if (load) begin
            full_d = 1'b0;
        end
        if (write_enable) begin
            if (full_q) begin
                ovr_d = 1'b1;
            end else begin
                full_d = 1'b1;
                hold_d = w_data[DATA_BITS-1:0];
            end
        end
    end

    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
        done_d = frame_end;
        case (state_d)
            S_IDLE:  busy_d = 1'b0;
            S_START: tx_d   = 1'b0;
            S_DATA:  tx_d   = shift_d[0];
            default: tx_d   = 1'b1;
        endcase
    end

    assign tx         = tx_q;
    assign tx_busy    = busy_q;
    assign tx_full    = full_q;
    assign tx_done    = done_q;
    assign tx_overrun = ovr_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter, 8N1 by default, LSB first. It takes bytes from the debug unit over the same byte-write interface the debug unit drives (`w_data` / `write_enable`) and shifts them out on `tx`. It is the transmit half paired with the existing receive path. A one-byte holding register lets the debug unit queue the next byte while the current frame is on the line, so consecutive frames go out with no idle gap.

## Interface

- `CLKS_PER_BIT`, default 5208: clock cycles per serial bit (50 MHz / 9600 baud); must be ≥ 2.
- `DATA_BITS`, default 8: data bits per frame; `w_data` uses the low `DATA_BITS` bits.
- `STOP_BITS`, default 1: stop bits per frame (1 or 2).

- `clk` input 1: system clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `w_data` input 8: byte to transmit; sampled only when `write_enable` = 1.
- `write_enable` input 1: single-cycle write strobe.
- `tx` output 1: serial line; idle high.
- `tx_busy` output 1: 1 while a frame (start, data or stop) is being shifted.
- `tx_full` output 1: holding register occupied.
- `tx_done` output 1: one-cycle pulse after the last stop-bit cycle of each frame.
- `tx_overrun` output 1: sticky; set when a write arrives while `tx_full` = 1; cleared only by reset.

## Operation

- Reset (`rst` = 0, async) forces the following:
  - Outputs: `tx` = 1, `tx_busy` = 0, `tx_full` = 0, `tx_done` = 0, `tx_overrun` = 0.
  - Internal state: FSM in IDLE; baud counter, bit index, shift register and holding register cleared.
- Write acceptance:
  - If `write_enable` = 1 and `tx_full` = 0 in the same cycle, the byte is latched into the holding register and `tx_full` = 1 from the next cycle.
  - If `write_enable` = 1 and `tx_full` = 1, the byte is dropped, the holding register is unchanged, and `tx_overrun` is set.
- FSM states are IDLE, START, DATA and STOP.
  - IDLE: `tx` = 1. If `tx_full` = 1, move the holding register into the shift register, clear `tx_full`, and go to START.
  - START: `tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index = 0.
  - DATA: `tx` = shift register bit 0 for `CLKS_PER_BIT` cycles, then shift right and increment the bit index. After bit `DATA_BITS`−1, go to STOP.
  - STOP: `tx` = 1 for `STOP_BITS`×`CLKS_PER_BIT` cycles. At the end of the last stop cycle, pulse `tx_done`. Then:
    - if `tx_full` = 1, transfer the holding register and go directly to START (no idle bit);
    - otherwise go to IDLE.
- The holding register frees when it is transferred. A write in that same cycle sees `tx_full` = 1 and is dropped (overrun). The writer must wait one cycle.
- The baud counter counts from 0 to `CLKS_PER_BIT`−1 and reloads to 0 on every state or bit change. Its width is ceil(log2(`CLKS_PER_BIT`)).
- `tx_busy` = 1 in START, DATA and STOP.

## Timing

- All outputs are registered; there is no combinational path from input to output.
- Write accepted at edge n in IDLE → `tx_full` = 1 after edge n → transfer and START entry at edge n+1 (`tx` falls and `tx_busy` rises after edge n+1; `tx_full` returns to 0).
- Frame length is (1 + `DATA_BITS` + `STOP_BITS`) × `CLKS_PER_BIT` cycles; with defaults this is 10 × 5208.
- `tx_done` is high for exactly one cycle, coincident with the transition out of STOP.
- When back-to-back writes are queued, the next start bit begins in the cycle immediately after the last stop-bit cycle.
- An asynchronous reset mid-frame returns `tx` to 1 immediately. There is no partial-frame completion, and the holding-register contents are discarded.

## Test plan

- Bench uses `CLKS_PER_BIT` = 4.
- Reset, then no writes for 100 cycles → `tx` = 1, `tx_busy` = 0, `tx_full` = 0 throughout.
- Write 0xA5 → sequence of 10 four-cycle bit periods: 0 (start), 1,0,1,0,0,1,0,1, 1 (stop). `tx_done` pulses once, 40 cycles after `tx` falls.
- Write 0x00, then write 0xFF while the first frame is in DATA → `tx_full` = 1. Frames are contiguous (stop bit immediately followed by start bit). Two `tx_done` pulses, 40 cycles apart. `tx_overrun` = 0.
- While 0x00 is being transmitted and 0xFF is held (`tx_full` = 1), write 0x3C → 0x3C never appears on `tx` and `tx_overrun` = 1, remaining 1 until reset.
- Assert `rst` = 0 during DATA of 0x55 → `tx` = 1 and all status outputs = 0 without waiting for a clock edge. After release, a new write of 0x81 transmits correctly.
- `STOP_BITS` = 2, write 0x0F → stop level held for 8 cycles. Frame is 44 cycles.
